// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and helpers for direct_mapped_dcache:
//   - WORD_W       : data word width (32)
//   - state_e      : controller states (IDLE / FILL / WRITE / WDONE)
//   - field_w()    : clog2-based width that never collapses to zero bits
//   - addr_offset(), addr_index(), addr_tag(), block_base() : byte-address
//     field extraction for a cache with 2^off_bits words per line and
//     2^idx_bits lines
// -----------------------------------------------------------------------------
package dcache_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_WDONE = 2'd3
   } state_e;

   // Width of a field able to index n entries; at least one bit so that
   // BLOCK_WORDS == 1 still yields a legal vector.
   function automatic int field_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int off_bits);
      return (addr >> 2) & ((32'd1 << off_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off_bits,
                                              input int idx_bits);
      return (addr >> (2 + off_bits)) & ((32'd1 << idx_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_bits,
                                            input int idx_bits);
      return addr >> (2 + off_bits + idx_bits);
   endfunction

   // First byte address of the line containing addr.
   function automatic logic [31:0] block_base(input logic [31:0] addr, input int off_bits);
      return (addr >> (2 + off_bits)) << (2 + off_bits);
   endfunction

endpackage

// File: rtl/direct_mapped_dcache_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces for direct_mapped_dcache.
//
// dcache_cpu_if : pipeline MM stage <-> cache
//   master (pipeline) drives cpu_addr, cpu_wdata, cpu_read, cpu_write
//   slave  (cache)    drives cpu_rdata, stall
// dcache_mem_if : cache <-> word-wide main memory
//   master (cache)    drives mem_req, mem_we, mem_addr, mem_wdata
//   slave  (memory)   drives mem_rdata, mem_ready
//
// Handshake: on the memory side mem_req acts as "valid" and mem_ready as
// "ready"; a transfer completes on exactly the rising edge where both are 1.
// While mem_req is high and the transfer has not completed, mem_we, mem_addr
// and mem_wdata are held stable. mem_rdata is only meaningful alongside
// mem_ready. On the CPU side, stall is the inverse of ready: a request
// completes on the edge where it is asserted and stall is 0, and the pipeline
// holds its request stable while stall is 1.
// -----------------------------------------------------------------------------
interface dcache_cpu_if;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_rdata;
   logic        stall;

   modport master (output cpu_addr, cpu_wdata, cpu_read, cpu_write,
                   input  cpu_rdata, stall);
   modport slave  (input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
                   output cpu_rdata, stall);
endinterface

interface dcache_mem_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_rdata, mem_ready);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_storage.sv
// -----------------------------------------------------------------------------
// dcache_storage
// Valid / tag / data arrays of the direct-mapped cache.
//   clk, rst_n            : clock, asynchronous active-low reset (clears valid)
//   rd_idx_i, rd_off_i    : combinational read port address
//   rd_valid_o, rd_tag_o,
//   rd_word_o             : selected line's valid bit, tag and data word
//   wr_en_i, wr_idx_i,
//   wr_off_i, wr_word_i   : synchronous single-word write port
//   line_we_i, line_idx_i,
//   line_tag_i,
//   line_valid_i          : line port; writes the valid bit and, when setting
//                           it, the tag
// -----------------------------------------------------------------------------
module dcache_storage #(
   parameter int LINES       = 64,
   parameter int BLOCK_WORDS = 4,
   parameter int IDX_W       = 6,
   parameter int OFF_W       = 2,
   parameter int TAG_W       = 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx_i,
   input  logic [OFF_W-1:0] rd_off_i,
   output logic             rd_valid_o,
   output logic [TAG_W-1:0] rd_tag_o,
   output logic [31:0]      rd_word_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [OFF_W-1:0] wr_off_i,
   input  logic [31:0]      wr_word_i,
   input  logic             line_we_i,
   input  logic [IDX_W-1:0] line_idx_i,
   input  logic [TAG_W-1:0] line_tag_i,
   input  logic             line_valid_i
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES][BLOCK_WORDS];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_word_o  = data_q[rd_idx_i][rd_off_i];

   // Tag and data carry no reset: they are only observed behind a valid bit.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         data_q[wr_idx_i][wr_off_i] <= wr_word_i;
      end
      if (line_we_i && line_valid_i) begin
         tag_q[line_idx_i] <= line_tag_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (line_we_i) begin
         valid_q[line_idx_i] <= line_valid_i;
      end
   end

endmodule

// File: rtl/direct_mapped_dcache.sv
// -----------------------------------------------------------------------------
// direct_mapped_dcache
// Direct-mapped, write-through, no-write-allocate data cache for the MM stage.
// Read hits return data in the same cycle; read misses fill the whole line
// word by word from main memory; every store is written through to memory.
//   clk, rst_n  : clock, asynchronous active-low reset
//   cpu         : dcache_cpu_if.slave  (cpu_addr/wdata/read/write in,
//                                       cpu_rdata/stall out)
//   mem         : dcache_mem_if.master (mem_req/we/addr/wdata out,
//                                       mem_rdata/ready in)
//   dbg_state_o : current controller state
// Optional build macro DCACHE_STATS_EN adds 32-bit wrapping outputs
//   hit_count, miss_count.
// -----------------------------------------------------------------------------
module direct_mapped_dcache
   import dcache_pkg::*;
#(
   parameter int LINES       = 64,
   parameter int BLOCK_WORDS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   dcache_cpu_if.slave  cpu,
   dcache_mem_if.master mem,
`ifdef DCACHE_STATS_EN
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count,
`endif
   output state_e       dbg_state_o
);

   localparam int OFF_BITS = $clog2(BLOCK_WORDS);
   localparam int IDX_BITS = $clog2(LINES);
   localparam int OFF_W    = field_w(BLOCK_WORDS);
   localparam int IDX_W    = field_w(LINES);
   localparam int TAG_W    = WORD_W - 2 - OFF_BITS - IDX_BITS;

   state_e           state_q;
   logic [OFF_W-1:0] cnt_q;
   logic [31:0]      lat_addr_q;
   logic             mem_req_q;
   logic             mem_we_q;
   logic [31:0]      mem_addr_q;
   logic [31:0]      mem_wdata_q;

   logic [31:0]      look_addr;
   logic [IDX_W-1:0] look_idx;
   logic [OFF_W-1:0] look_off;
   logic [TAG_W-1:0] look_tag;
   logic             line_valid;
   logic [TAG_W-1:0] line_tag;
   logic [31:0]      line_word;
   logic             hit;
   logic             xfer_done;
   logic             fill_last;
   logic             rd_miss;

   logic             word_we;
   logic [OFF_W-1:0] word_off;
   logic [31:0]      word_data;
   logic             line_we;
   logic             line_set;
   logic             stall_c;

   // In IDLE the live request is looked up; elsewhere the latched one, so
   // FILL and WRITE never depend on the pipeline holding its inputs.
   assign look_addr = (state_q == ST_IDLE) ? cpu.cpu_addr : lat_addr_q;
   assign look_idx  = IDX_W'(addr_index(look_addr, OFF_BITS, IDX_BITS));
   assign look_off  = OFF_W'(addr_offset(look_addr, OFF_BITS));
   assign look_tag  = TAG_W'(addr_tag(look_addr, OFF_BITS, IDX_BITS));

   assign hit       = line_valid && (line_tag == look_tag);
   assign xfer_done = mem_req_q && mem.mem_ready;
   assign fill_last = (state_q == ST_FILL) && xfer_done &&
                      (cnt_q == OFF_W'(BLOCK_WORDS - 1));
   assign rd_miss   = (state_q == ST_IDLE) && cpu.cpu_read && !cpu.cpu_write && !hit;

   dcache_storage #(
      .LINES       (LINES),
      .BLOCK_WORDS (BLOCK_WORDS),
      .IDX_W       (IDX_W),
      .OFF_W       (OFF_W),
      .TAG_W       (TAG_W)
   ) u_storage (
      .clk          (clk),
      .rst_n        (rst_n),
      .rd_idx_i     (look_idx),
      .rd_off_i     (look_off),
      .rd_valid_o   (line_valid),
      .rd_tag_o     (line_tag),
      .rd_word_o    (line_word),
      .wr_en_i      (word_we),
      .wr_idx_i     (look_idx),
      .wr_off_i     (word_off),
      .wr_word_i    (word_data),
      .line_we_i    (line_we),
      .line_idx_i   (look_idx),
      .line_tag_i   (look_tag),
      .line_valid_i (line_set)
   );

   // Storage write controls. The line is invalidated in the cycle the miss
   // is detected and only re-validated with the last fill word, so a
   // partially filled line never produces a hit.
   always_comb begin
      word_we   = 1'b0;
      word_off  = cnt_q;
      word_data = mem.mem_rdata;
      line_we   = 1'b0;
      line_set  = 1'b0;
      if ((state_q == ST_FILL) && xfer_done) begin
         word_we = 1'b1;
      end
      if ((state_q == ST_WRITE) && xfer_done && hit) begin
         word_we   = 1'b1;
         word_off  = look_off;
         word_data = mem_wdata_q;
      end
      if (rd_miss) begin
         line_we = 1'b1;
      end
      if (fill_last) begin
         line_we  = 1'b1;
         line_set = 1'b1;
      end
   end

   always_comb begin
      stall_c = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_IDLE:           stall_c = (cpu.cpu_read && !hit) || cpu.cpu_write;
            ST_FILL, ST_WRITE: stall_c = 1'b1;
            default:           stall_c = 1'b0;
         endcase
      end
   end

   assign cpu.stall     = stall_c;
   assign cpu.cpu_rdata = (rst_n && (state_q == ST_IDLE) && hit) ? line_word : 32'h0;

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign dbg_state_o   = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         lat_addr_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cpu.cpu_write) begin
                  state_q     <= ST_WRITE;
                  lat_addr_q  <= cpu.cpu_addr;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {cpu.cpu_addr[31:2], 2'b00};
                  mem_wdata_q <= cpu.cpu_wdata;
               end else if (rd_miss) begin
                  state_q    <= ST_FILL;
                  lat_addr_q <= cpu.cpu_addr;
                  cnt_q      <= '0;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= block_base(cpu.cpu_addr, OFF_BITS);
               end
            end
            ST_FILL: begin
               if (xfer_done) begin
                  cnt_q      <= cnt_q + 1'b1;
                  mem_addr_q <= mem_addr_q + 32'd4;
                  if (fill_last) begin
                     state_q   <= ST_IDLE;
                     mem_req_q <= 1'b0;
                  end
               end
            end
            ST_WRITE: begin
               if (xfer_done) begin
                  state_q   <= ST_WDONE;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
               end
            end
            ST_WDONE: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;
   logic        replay_q;

   // replay_q marks the IDLE cycle right after a fill: that hit is the
   // replay of an already counted miss, not a new first-evaluation hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         replay_q   <= 1'b0;
      end else begin
         replay_q <= fill_last;
         if ((state_q == ST_IDLE) && cpu.cpu_read && !cpu.cpu_write) begin
            if (hit && !replay_q) begin
               hit_cnt_q <= hit_cnt_q + 32'd1;
            end else if (!hit) begin
               miss_cnt_q <= miss_cnt_q + 32'd1;
            end
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_direct_mapped_dcache.sv
// -----------------------------------------------------------------------------
// tb_direct_mapped_dcache
// Self-checking bench for direct_mapped_dcache (LINES=64, BLOCK_WORDS=4).
// A behavioural memory answers the cache with a programmable number of wait
// cycles; a reference model (word memory + per-line valid/tag computed from
// address arithmetic) predicts hit/miss, stall length, memory transfers and
// load data. Directed scenarios come first, then randomized accesses.
// -----------------------------------------------------------------------------
module tb_direct_mapped_dcache;
   import dcache_pkg::*;

   localparam int LINES = 64;
   localparam int BW    = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_cpu_if cpu_bus ();
   dcache_mem_if mem_bus ();
   state_e       dbg_state;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
`endif

   direct_mapped_dcache #(
      .LINES       (LINES),
      .BLOCK_WORDS (BW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu         (cpu_bus),
      .mem         (mem_bus),
`ifdef DCACHE_STATS_EN
      .hit_count   (hit_count),
      .miss_count  (miss_count),
`endif
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [65:0] exp_q[$];            // {present, we, addr, wdata-or-0}
   int wait_cycles = 0;
   int wait_cnt    = 0;
   int xfer_n      = 0;

   // Memory contents as seen by the memory responder (written by DUT stores)
   logic [31:0] mem_arr [int unsigned];
   // Reference model
   logic [31:0] ref_mem [int unsigned];
   bit          ref_valid [LINES];
   int unsigned ref_tag   [LINES];
   int          exp_hits   = 0;
   int          exp_misses = 0;

   task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] default_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return default_word(a);
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return default_word(a);
   endfunction

   // ---------------- memory responder / transfer monitor ----------------
   initial begin
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 32'h0;
   end

   always @(negedge clk) begin
      mem_bus.mem_ready = mem_bus.mem_req && (wait_cnt >= wait_cycles);
      mem_bus.mem_rdata = mem_word(mem_bus.mem_addr);
   end

   always @(posedge clk) begin
      logic [65:0] obs;
      if (rst_n && mem_bus.mem_req && mem_bus.mem_ready) begin
         obs = {1'b1, mem_bus.mem_we, mem_bus.mem_addr,
                mem_bus.mem_we ? mem_bus.mem_wdata : 32'h0};
         if (exp_q.size() == 0) check_eq("xfer_unexpected", obs, 66'h0);
         else                   check_eq("xfer", obs, exp_q.pop_front());
         if (mem_bus.mem_we) mem_arr[mem_bus.mem_addr] = mem_bus.mem_wdata;
         xfer_n++;
         wait_cnt = 0;
      end else if (rst_n && mem_bus.mem_req) begin
         wait_cnt++;
      end else begin
         wait_cnt = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic model_reset();
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
      exp_q.delete();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      cpu_bus.cpu_read  = 1'b0;
      cpu_bus.cpu_write = 1'b0;
      model_reset();
      wait_cycles = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One pipeline access, started just after a rising edge. Predicts the
   // outcome from the reference model, runs it to completion, checks it.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input int wt,
                            output int cyc, output logic [31:0] rdata);
      logic [31:0] wa;
      logic [31:0] base;
      int unsigned li;
      int unsigned lt;
      bit hit;
      bit done;
      int exp_cyc;
      wa   = a & ~32'h3;
      li   = (a / (4 * BW)) % LINES;
      lt   = a / (4 * BW * LINES);
      hit  = ref_valid[li] && (ref_tag[li] == lt);
      wait_cycles = wt;
      if (wr) begin
         exp_cyc = 2 + wt;
         exp_q.push_back({1'b1, 1'b1, wa, wd});
      end else if (rd && !hit) begin
         exp_cyc = 1 + BW * (1 + wt);
         base = a & ~(32'(4 * BW) - 32'd1);
         for (int k = 0; k < BW; k++) exp_q.push_back({1'b1, 1'b0, base + 32'(4 * k), 32'h0});
      end else begin
         exp_cyc = 0;
      end

      cpu_bus.cpu_addr  = a;
      cpu_bus.cpu_wdata = wd;
      cpu_bus.cpu_read  = rd;
      cpu_bus.cpu_write = wr;
      cyc  = 0;
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         if (!cpu_bus.stall) done = 1'b1;
         else begin
            cyc++;
            @(posedge clk);
            #1;
         end
      end
      rdata = cpu_bus.cpu_rdata;
      check_eq("access_done", 66'(done), 66'd1);
      check_eq("stall_cycles", 66'(cyc), 66'(exp_cyc));
      if (rd && !wr) check_eq("rdata", 66'(rdata), 66'(ref_word(wa)));
      @(posedge clk);
      #1;
      cpu_bus.cpu_read  = 1'b0;
      cpu_bus.cpu_write = 1'b0;
      check_eq("state_idle", 66'(dbg_state), 66'(ST_IDLE));
      check_eq("xfers_left", 66'(exp_q.size()), 66'd0);
      exp_q.delete();

      if (wr) ref_mem[wa] = wd;
      else if (rd) begin
         if (hit) exp_hits++;
         else begin
            exp_misses++;
            ref_valid[li] = 1'b1;
            ref_tag[li]   = lt;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          cyc;
      int          total;
      int          x0;
      bit          got;
      logic [31:0] rdata;
      logic [31:0] a;
      int          kind;

      for (int k = 0; k < BW; k++) begin
         mem_arr[32'h100 + 32'(4 * k)] = 32'hA0 + 32'(k);
         ref_mem[32'h100 + 32'(4 * k)] = 32'hA0 + 32'(k);
      end
      model_reset();

      // Reset state, with a read request presented to prove stall is forced 0
      cpu_bus.cpu_addr  = 32'h100;
      cpu_bus.cpu_wdata = 32'h0;
      cpu_bus.cpu_read  = 1'b1;
      cpu_bus.cpu_write = 1'b0;
      #3;
      check_eq("rst_stall", 66'(cpu_bus.stall), 66'd0);
      check_eq("rst_mem_req", 66'(mem_bus.mem_req), 66'd0);
      check_eq("rst_mem_we", 66'(mem_bus.mem_we), 66'd0);
      check_eq("rst_mem_addr", 66'(mem_bus.mem_addr), 66'd0);
      check_eq("rst_mem_wdata", 66'(mem_bus.mem_wdata), 66'd0);
      check_eq("rst_rdata", 66'(cpu_bus.cpu_rdata), 66'd0);
      check_eq("rst_state", 66'(dbg_state), 66'(ST_IDLE));
`ifdef DCACHE_STATS_EN
      check_eq("rst_hits", 66'(hit_count), 66'd0);
      check_eq("rst_misses", 66'(miss_count), 66'd0);
`endif
      apply_reset();

      // Fill, hit, store-hit, load-back, store-miss, load-miss
      do_access(1, 0, 32'h100, 32'h0, 0, cyc, rdata);
      check_eq("fill_stall", 66'(cyc), 66'd5);
      check_eq("fill_rdata", 66'(rdata), 66'hA0);
      do_access(1, 0, 32'h108, 32'h0, 0, cyc, rdata);
      check_eq("hit_stall", 66'(cyc), 66'd0);
      check_eq("hit_rdata", 66'(rdata), 66'hA2);
      do_access(0, 1, 32'h104, 32'hDEAD, 0, cyc, rdata);
      check_eq("store_stall", 66'(cyc), 66'd2);
      do_access(1, 0, 32'h104, 32'h0, 0, cyc, rdata);
      check_eq("store_hit_load", 66'(rdata), 66'hDEAD);
      do_access(0, 1, 32'h900, 32'h1234_5678, 0, cyc, rdata);
      do_access(1, 0, 32'h900, 32'h0, 0, cyc, rdata);
      check_eq("no_alloc_miss", 66'(cyc), 66'd5);
      check_eq("no_alloc_rdata", 66'(rdata), 66'h1234_5678);

      // Conflict on one index
      apply_reset();
      total = 0;
      do_access(1, 0, 32'h000, 32'h0, 0, cyc, rdata); total += cyc;
      do_access(1, 0, 32'h400, 32'h0, 0, cyc, rdata); total += cyc;
      do_access(1, 0, 32'h000, 32'h0, 0, cyc, rdata); total += cyc;
      check_eq("conflict_stall", 66'(total), 66'd15);
`ifdef DCACHE_STATS_EN
      check_eq("conflict_misses", 66'(miss_count), 66'd3);
      check_eq("conflict_hits", 66'(hit_count), 66'd0);
`endif

      // Slow memory
      do_access(1, 0, 32'h2000, 32'h0, 2, cyc, rdata);
      check_eq("slow_fill_stall", 66'(cyc), 66'd13);

      // Reset during the third transfer of a fill
      x0 = xfer_n;
      wait_cycles = 2;
      for (int k = 0; k < BW; k++) exp_q.push_back({1'b1, 1'b0, 32'h3000 + 32'(4 * k), 32'h0});
      cpu_bus.cpu_addr  = 32'h3000;
      cpu_bus.cpu_read  = 1'b1;
      cpu_bus.cpu_write = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         if (xfer_n >= x0 + 2) got = 1'b1;
      end
      check_eq("third_xfer_reached", 66'(got), 66'd1);
      check_eq("third_xfer_req", {mem_bus.mem_req, mem_bus.mem_addr}, {33'd0, 1'b1, 32'h3008});
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("abort_mem_req", 66'(mem_bus.mem_req), 66'd0);
      check_eq("abort_stall", 66'(cpu_bus.stall), 66'd0);
      check_eq("abort_mem_addr", 66'(mem_bus.mem_addr), 66'd0);
      apply_reset();
      do_access(1, 0, 32'h3000, 32'h0, 2, cyc, rdata);
      check_eq("post_abort_miss", 66'(cyc), 66'd13);

      // Randomized traffic over a few tags and indices to mix hits,
      // conflicts, stores to cached and uncached lines, and wait states
      for (int n = 0; n < 120; n++) begin
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         kind = $urandom_range(0, 9);
         if (kind < 6)      do_access(1, 0, a, $urandom, $urandom_range(0, 2), cyc, rdata);
         else if (kind < 9) do_access(0, 1, a, $urandom, $urandom_range(0, 2), cyc, rdata);
         else               do_access(1, 1, a, $urandom, $urandom_range(0, 2), cyc, rdata);
      end
`ifdef DCACHE_STATS_EN
      check_eq("final_hits", 66'(hit_count), 66'(exp_hits));
      check_eq("final_misses", 66'(miss_count), 66'(exp_misses));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/direct_mapped_dcache.md
# direct_mapped_dcache

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory stage and a slower word-wide main memory. It replaces the single-cycle data memory in the MM stage: hits return data combinationally in the same cycle, and misses and writes raise `stall` until main memory completes.

## Interface
Parameters:
- `LINES`, default 64: number of cache lines; power of 2, at least 2.
- `BLOCK_WORDS`, default 4: 32-bit words per line; power of 2, at least 1.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_addr` in 32: byte address (ALU result); bits [1:0] ignored.
- `cpu_wdata` in 32: store data.
- `cpu_read` in 1: load request.
- `cpu_write` in 1: store request; wins if asserted together with `cpu_read`.
- `cpu_rdata` out 32: load data, valid when `cpu_read & !stall`.
- `stall` out 1: freezes the pipeline (PC, IF/ID, ID/EX, EX/MM).
- `mem_req` out 1: main-memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid with `mem_ready`.
- `mem_ready` in 1: transfer completes on an edge where `mem_req & mem_ready`.

## Operation
- Address split:
  - offset = `cpu_addr[2 +: log2(BLOCK_WORDS)]`
  - index = the next log2(`LINES`) bits
  - tag = the remaining upper bits
- Hit = `valid[index] & tag_array[index] == tag`.
- Each line holds one valid bit, one tag and `BLOCK_WORDS` data words.
- FSM states: IDLE, FILL, WRITE, WDONE.
- IDLE:
  - `stall = (cpu_read & !hit) | cpu_write`.
  - On a read hit, `cpu_rdata` = `data[index][offset]`. There is no state change.
  - On a read miss, go to FILL. Latch the block base address and tag, and set the word counter to 0.
  - On a write, go to WRITE. Latch the address and data.
- FILL:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr` = base + 4·counter.
  - Each completed transfer writes `mem_rdata` into `data[index][counter]` and increments the counter.
  - On the last word, write the tag, set valid, and return to IDLE. The request then replays as a hit.
  - Valid is cleared on entering FILL, so a partially filled line is never visible.
- WRITE:
  - Drive `mem_req`=1, `mem_we`=1, with the latched address and data.
  - On completion, if the line hits, update its word (no-write-allocate on a miss). Then go to WDONE.
- WDONE: `stall`=0 for one cycle so the pipeline retires the store. Then go to IDLE.
- When neither read nor write is requested in IDLE, `stall`=0 and nothing happens.
- A line whose index matches but whose tag differs is replaced on a read miss. Nothing is written back, because the cache is write-through.
- Outside IDLE, `cpu_addr`/`cpu_read`/`cpu_write` are not re-sampled. Under stall the pipeline holds them stable.

## Timing
- Reset values (asynchronous): state IDLE, all valid bits 0, counter 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_rdata` 0, statistic counters 0. `stall` is forced to 0 while `rst_n` is low.
- Hit: 0 stall cycles.
- Read miss with zero-wait memory: `BLOCK_WORDS` + 1 stall cycles (the IDLE detect cycle plus the FILL cycles). Each memory wait cycle adds one.
- Store with zero-wait memory: 2 stall cycles (IDLE, then WRITE), followed by WDONE.
- `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are registered. They stay stable until the transfer completes.
- Reset asserted mid-FILL or mid-WRITE aborts immediately. The line being filled stays invalid, and `mem_req` drops asynchronously.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds 32-bit outputs `hit_count` and `miss_count`.
  - `hit_count` increments once per completed read that hit on its first IDLE evaluation.
  - `miss_count` increments once per read miss, on the IDLE→FILL transition.
  - Both counters wrap at 2³².
- `DCACHE_STATS_EN` undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `dcache_pkg` holds:
  - the state enum (IDLE/FILL/WRITE/WDONE)
  - a `clog2`-based width helper
  - address-field extraction functions (tag/index/offset)
  - the word-size constant 32
- Sub-module `dcache_storage` holds the valid, tag and data arrays:
  - combinational read port
  - synchronous word-write port
  - line-fill tag/valid-write port
  - asynchronous valid clear
- The top level holds the FSM, counters and memory interface.

## Test plan
- Reset, then read 0x100 with zero-wait memory returning 0xA0+k for word k: `stall` high for 5 cycles, 4 memory reads at 0x100–0x10C, then `cpu_rdata`=0xA0.
- Immediately read 0x108 after that fill: hit, `stall`=0, `cpu_rdata`=0xA2, no `mem_req`.
- Store 0xDEAD to 0x104 (hit), then load 0x104: one memory write at 0x104, 2 stall cycles, WDONE, then the load hits with 0xDEAD. Storing to an uncached 0x900 writes memory only, and a later load of 0x900 misses.
- Conflict: with LINES=64 and BLOCK_WORDS=4, read 0x000, then 0x400 (same index), then 0x000: three misses, 15 stall cycles total. With `DCACHE_STATS_EN`, `miss_count`=3 and `hit_count`=0.
- With `mem_ready` delayed by 2 cycles per transfer, a read miss gives 13 stall cycles. Asserting `rst_n` low during the 3rd transfer drops `mem_req` and `stall`; a post-reset read of the same address misses.
